// File: rtl/memory_stage.sv
// Memory pipeline stage: registers execute results for writeback and runs
// data-memory loads/stores over a ready handshake, stalling execute meanwhile.
module memory_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble_in,
  input  logic [WIDTH-1:0] instr_in,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] store_data_in,
  input  logic             halt_in,
  output logic             stall,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             bubble_out,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] mem_out
);

  localparam logic IDLE = 1'b0;
  localparam logic REQ  = 1'b1;

  logic             state_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] instr_reg;

  logic accept;
  logic in_is_load, in_is_store, in_is_mem;
  logic lat_is_load, lat_is_store;

  assign accept      = !bubble_in && !halt_in;
  assign in_is_load  = (instr_in[15:12] == 4'hF) && (instr_in[7:4] == 4'h0);
  assign in_is_store = (instr_in[15:12] == 4'hF) && (instr_in[7:4] == 4'h1);
  assign in_is_mem   = in_is_load || in_is_store;

  assign lat_is_load  = (instr_reg[15:12] == 4'hF) && (instr_reg[7:4] == 4'h0);
  assign lat_is_store = (instr_reg[15:12] == 4'hF) && (instr_reg[7:4] == 4'h1);

  // Request strobes decode only registered state so reset drops them at once.
  assign stall     = (state_reg == REQ);
  assign mem_re    = stall && lat_is_load;
  assign mem_we    = stall && lat_is_store;
  assign mem_addr  = addr_reg;
  assign mem_wdata = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      data_reg   <= '0;
      instr_reg  <= '0;
      bubble_out <= 1'b1;
      instr_out  <= '0;
      alu_out    <= '0;
      mem_out    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          bubble_out <= 1'b1;
          if (accept && !in_is_mem) begin
            bubble_out <= 1'b0;
            instr_out  <= instr_in;
            alu_out    <= alu_in;
            mem_out    <= '0;
          end else if (accept) begin
            instr_reg <= instr_in;
            addr_reg  <= alu_in;
            data_reg  <= store_data_in;
            state_reg <= REQ;
          end
        end
        default: begin
          // halt_in is deliberately ignored: an in-flight access always finishes.
          bubble_out <= 1'b1;
          if (mem_ready) begin
            state_reg  <= IDLE;
            bubble_out <= 1'b0;
            instr_out  <= instr_reg;
            alu_out    <= addr_reg;
            mem_out    <= lat_is_load ? mem_rdata : '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a per-cycle vector table plus hand-written
// reset sequences.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bubble_in;
  logic [15:0] instr_in, alu_in, store_data_in;
  logic        halt_in;
  logic        stall;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_re, mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        bubble_out;
  logic [15:0] instr_out, alu_out, mem_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bubble_in(bubble_in), .instr_in(instr_in),
    .alu_in(alu_in), .store_data_in(store_data_in), .halt_in(halt_in),
    .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .bubble_out(bubble_out), .instr_out(instr_out),
    .alu_out(alu_out), .mem_out(mem_out)
  );

  typedef struct {
    logic        bub;
    logic [15:0] instr;
    logic [15:0] alu;
    logic [15:0] sdata;
    logic        halt;
    logic        rdy;
    logic [15:0] rdata;
    logic        e_bo;
    logic [15:0] e_io;
    logic [15:0] e_ao;
    logic [15:0] e_mo;
    logic        e_stall;
    logic        e_re;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic bo, input logic [15:0] io,
                         input logic [15:0] ao, input logic [15:0] mo,
                         input logic st, input logic re, input logic we);
    chk({tag, ".bubble_out"}, {15'd0, bubble_out}, {15'd0, bo});
    chk({tag, ".instr_out"}, instr_out, io);
    chk({tag, ".alu_out"}, alu_out, ao);
    chk({tag, ".mem_out"}, mem_out, mo);
    chk({tag, ".stall"}, {15'd0, stall}, {15'd0, st});
    chk({tag, ".mem_re"}, {15'd0, mem_re}, {15'd0, re});
    chk({tag, ".mem_we"}, {15'd0, mem_we}, {15'd0, we});
  endtask

  task automatic idle_inputs();
    bubble_in = 1'b1; instr_in = 16'h0; alu_in = 16'h0; store_data_in = 16'h0;
    halt_in = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0;
  endtask

  initial begin
    // bub, instr, alu, sdata, halt, rdy, rdata | bo, io, ao, mo, stall, re, we, addr, wd
    tbl[0]  = '{1'b0, 16'h0123, 16'h00AA, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0123, 16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0123, 16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 16'hF005, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0123, 16'h00AA, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000};
    tbl[3]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0123, 16'h00AA, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000};
    tbl[4]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0123, 16'h00AA, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000};
    tbl[5]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0123, 16'h00AA, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000};
    tbl[6]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'hF005, 16'h0040, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000};
    tbl[7]  = '{1'b0, 16'hF010, 16'h0007, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hF005, 16'h0040, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'h0007, 16'h1234};
    tbl[8]  = '{1'b0, 16'h8001, 16'h0055, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hF010, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h1234};
    tbl[9]  = '{1'b0, 16'h8001, 16'h0055, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h8001, 16'h0055, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h1234};
    tbl[10] = '{1'b0, 16'hF005, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h8001, 16'h0055, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000};
    tbl[11] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1111, 1'b0, 16'hF005, 16'h0020, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000};
    tbl[12] = '{1'b0, 16'h0456, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hF005, 16'h0020, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000};
    tbl[13] = '{1'b0, 16'h0456, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hF005, 16'h0020, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000};
    tbl[14] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b1, 16'hF005, 16'h0020, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000};
    tbl[15] = '{1'b0, 16'hF105, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hF005, 16'h0020, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000};
    tbl[16] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h00CC, 1'b0, 16'hF105, 16'h0003, 16'h00CC, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000};
    tbl[17] = '{1'b0, 16'hF025, 16'h0099, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hF025, 16'h0099, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000};

    // Reset held with random inputs.
    rst_n = 1'b0;
    bubble_in = 1'b0; instr_in = 16'hF005; alu_in = 16'($urandom);
    store_data_in = 16'($urandom); halt_in = 1'b0;
    mem_ready = 1'b1; mem_rdata = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      instr_in = 16'($urandom); alu_in = 16'($urandom);
      bubble_in = 1'($urandom); mem_ready = 1'($urandom);
    end
    chk_all("reset", 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.mem_addr", mem_addr, 16'h0);
    chk("reset.mem_wdata", mem_wdata, 16'h0);
    $display("reset held: bubble_out=%b stall=%b re=%b we=%b", bubble_out, stall, mem_re, mem_we);

    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset", 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < 18; v++) begin
      bubble_in = tbl[v].bub; instr_in = tbl[v].instr; alu_in = tbl[v].alu;
      store_data_in = tbl[v].sdata; halt_in = tbl[v].halt;
      mem_ready = tbl[v].rdy; mem_rdata = tbl[v].rdata;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", v), tbl[v].e_bo, tbl[v].e_io, tbl[v].e_ao,
              tbl[v].e_mo, tbl[v].e_stall, tbl[v].e_re, tbl[v].e_we);
      chk($sformatf("vec%0d.mem_addr", v), mem_addr, tbl[v].e_addr);
      chk($sformatf("vec%0d.mem_wdata", v), mem_wdata, tbl[v].e_wd);
      $display("vec%0d: instr_in=%h rdy=%b -> bubble_out=%b instr_out=%h alu_out=%h mem_out=%h stall=%b re=%b we=%b",
               v, tbl[v].instr, tbl[v].rdy, bubble_out, instr_out, alu_out, mem_out, stall, mem_re, mem_we);
    end

    // Reset asserted mid-REQ abandons the pending load immediately.
    bubble_in = 1'b0; instr_in = 16'hF005; alu_in = 16'h0030; halt_in = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("midreq.pre_re", {15'd0, mem_re}, 16'h1);
    chk("midreq.pre_stall", {15'd0, stall}, 16'h1);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midreq_reset", 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    $display("mid-REQ reset: re=%b stall=%b bubble_out=%b", mem_re, stall, bubble_out);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    @(posedge clk); #1;
    chk_all("after_midreq", 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
